// File: rtl/tt_io_conditioner.sv
// tt_io_conditioner
//   Input-conditioning front end for Tiny Tapeout user designs. It produces a
//   reset that asserts asynchronously and deasserts on the clock. Each raw pin
//   channel goes through a synchroniser and a debouncer. The channel then gets
//   press/release pulses and, if enabled, auto-repeat press pulses while the
//   button stays held.
//
// Ports
//   clk           : single clock, all state lives here
//   rst_n         : asynchronous active-low reset
//   ena           : design enable; when low, debounce/repeat state freezes and
//                   pulses are suppressed (synchronisers keep running)
//   raw_in        : [NUM_CH] asynchronous raw pins, active-high
//   repeat_en     : [NUM_CH] per-channel auto-repeat enable (quasi-static)
//   rst_sync_n    : synchronised reset for downstream logic
//   level         : [NUM_CH] debounced level
//   press         : [NUM_CH] one-cycle pulse on debounced rise and each repeat
//   release_pulse : [NUM_CH] one-cycle pulse on debounced fall
//                   ("release" is a reserved word in SystemVerilog)
module tt_io_conditioner #(
  parameter int NUM_CH          = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int REPEAT_DELAY    = 65536,
  parameter int REPEAT_PERIOD   = 8192
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [NUM_CH-1:0] raw_in,
  input  logic [NUM_CH-1:0] repeat_en,
  output logic              rst_sync_n,
  output logic [NUM_CH-1:0] level,
  output logic [NUM_CH-1:0] press,
  output logic [NUM_CH-1:0] release_pulse
);

  localparam int DC_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RC_W   = $clog2(RC_MAX) + 1;

  localparam logic [DC_W-1:0] DC_LAST     = DC_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RC_W-1:0] DELAY_LAST  = RC_W'(REPEAT_DELAY - 1);
  localparam logic [RC_W-1:0] PERIOD_LAST = RC_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    RPT  = 2'd2
  } rpt_state_t;

  // Reset synchroniser: fed with 1, cleared asynchronously by rst_n.
  logic [1:0] rst_pipe_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_pipe_reg <= 2'b00;
    end else begin
      rst_pipe_reg <= {rst_pipe_reg[0], 1'b1};
    end
  end

  assign rst_sync_n = rst_pipe_reg[1];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_reg;
      logic                   s;
      logic [DC_W-1:0]        dc_reg, dc_next;
      logic                   level_reg, level_next;
      logic [RC_W-1:0]        rc_reg, rc_next;
      rpt_state_t             state_reg, state_next;
      logic                   press_reg, press_next;
      logic                   rel_reg, rel_next;
      logic                   rise, fall;

      // Synchroniser runs regardless of ena so the sample is always fresh.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_reg <= '0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw_in[gi]};
        end
      end

      assign s = sync_reg[SYNC_STAGES-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dc_reg    <= '0;
          level_reg <= 1'b0;
          rc_reg    <= '0;
          state_reg <= IDLE;
          press_reg <= 1'b0;
          rel_reg   <= 1'b0;
        end else begin
          dc_reg    <= dc_next;
          level_reg <= level_next;
          rc_reg    <= rc_next;
          state_reg <= state_next;
          press_reg <= press_next;
          rel_reg   <= rel_next;
        end
      end

      // Debounce and repeat logic share one decision so that the level edge,
      // its pulse and the FSM transition all land on the same clock edge.
      always_comb begin
        dc_next    = dc_reg;
        level_next = level_reg;
        rc_next    = rc_reg;
        state_next = state_reg;
        press_next = 1'b0;
        rel_next   = 1'b0;
        rise       = 1'b0;
        fall       = 1'b0;

        if (ena) begin
          if (s == level_reg) begin
            dc_next = '0;
          end else if (dc_reg == DC_LAST) begin
            level_next = s;
            dc_next    = '0;
            rise       = s;
            fall       = ~s;
          end else begin
            dc_next = dc_reg + DC_W'(1);
          end

          // A fall overrides any repeat pulse due on the same edge.
          if (fall) begin
            state_next = IDLE;
            rc_next    = '0;
            rel_next   = 1'b1;
          end else begin
            case (state_reg)
              IDLE: begin
                if (rise) begin
                  state_next = HELD;
                  rc_next    = '0;
                  press_next = 1'b1;
                end
              end
              HELD: begin
                if (!repeat_en[gi]) begin
                  rc_next = '0;
                end else if (rc_reg == DELAY_LAST) begin
                  press_next = 1'b1;
                  rc_next    = '0;
                  state_next = RPT;
                end else begin
                  rc_next = rc_reg + RC_W'(1);
                end
              end
              RPT: begin
                if (!repeat_en[gi]) begin
                  state_next = HELD;
                  rc_next    = '0;
                end else if (rc_reg == PERIOD_LAST) begin
                  press_next = 1'b1;
                  rc_next    = '0;
                end else begin
                  rc_next = rc_reg + RC_W'(1);
                end
              end
              default: begin
                state_next = IDLE;
                rc_next    = '0;
              end
            endcase
          end
        end
      end

      assign level[gi]         = level_reg;
      assign press[gi]         = press_reg;
      assign release_pulse[gi] = rel_reg;
    end
  endgenerate

endmodule

// File: tb/tb_tt_io_conditioner.sv
// Testbench for tt_io_conditioner with NUM_CH=2, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4, REPEAT_DELAY=6, REPEAT_PERIOD=3.
module tb_tt_io_conditioner;

  localparam int NCH = 2;
  localparam int SYN = 2;
  localparam int DEB = 4;
  localparam int DLY = 6;
  localparam int PER = 3;

  logic           clk;
  logic           rst_n;
  logic           ena;
  logic [NCH-1:0] raw_in;
  logic [NCH-1:0] repeat_en;
  logic           rst_sync_n;
  logic [NCH-1:0] level;
  logic [NCH-1:0] press;
  logic [NCH-1:0] release_pulse;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  tt_io_conditioner #(
    .NUM_CH(NCH), .SYNC_STAGES(SYN), .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .raw_in(raw_in), .repeat_en(repeat_en),
    .rst_sync_n(rst_sync_n), .level(level), .press(press), .release_pulse(release_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Level accepts a change once the synchronised sample has disagreed with it
  // for DEB consecutive enabled samples. While held, 'age' counts enabled
  // cycles since the press (reset whenever repeat is disabled); repeats fall
  // at age DLY, DLY+PER, DLY+2*PER, ...
  logic [NCH-1:0] h0, h1;
  logic [NCH-1:0] m_lvl, m_press, m_rel;
  int             m_run  [NCH];
  int             m_age  [NCH];
  bit             m_held [NCH];
  int             rst_edges;
  logic           m_rsn;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h0 = '0; h1 = '0; m_lvl = '0; m_press = '0; m_rel = '0;
      rst_edges = 0; m_rsn = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        m_run[c] = 0; m_age[c] = 0; m_held[c] = 1'b0;
      end
    end else begin
      logic [NCH-1:0] s;
      rst_edges++;
      m_rsn = (rst_edges >= 2);
      s  = h1;
      h1 = h0;
      h0 = raw_in;
      m_press = '0;
      m_rel   = '0;
      if (ena) begin
        for (int c = 0; c < NCH; c++) begin
          bit changed;
          changed = 1'b0;
          if (s[c] != m_lvl[c]) begin
            m_run[c]++;
            if (m_run[c] == DEB) begin
              m_lvl[c] = s[c];
              m_run[c] = 0;
              changed = 1'b1;
            end
          end else begin
            m_run[c] = 0;
          end
          if (changed && !m_lvl[c]) begin
            m_rel[c] = 1'b1; m_held[c] = 1'b0; m_age[c] = 0;
          end else if (changed) begin
            m_press[c] = 1'b1; m_held[c] = 1'b1; m_age[c] = 0;
          end else if (m_held[c]) begin
            if (!repeat_en[c]) begin
              m_age[c] = 0;
            end else begin
              m_age[c]++;
              if (m_age[c] == DLY || (m_age[c] > DLY && (m_age[c] - DLY) % PER == 0))
                m_press[c] = 1'b1;
            end
          end
        end
      end
    end
  end

  // Every cycle, outputs are compared with the model away from the active edge.
  always @(negedge clk) begin
    check("cyc_rst_sync_n", 32'(rst_sync_n), 32'(m_rsn));
    check("cyc_level", 32'(level), 32'(m_lvl));
    check("cyc_press", 32'(press), 32'(m_press));
    check("cyc_release", 32'(release_pulse), 32'(m_rel));
  end

  task automatic settle(input int n);
    raw_in = '0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int cnt0, cnt1;
    int q0[$];

    rst_n = 1'b1; ena = 1'b1; raw_in = '0; repeat_en = '0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_sync_n_init", 32'(rst_sync_n), 32'd0);
    check("level_init", 32'(level), 32'd0);
    check("press_init", 32'(press), 32'd0);
    check("release_init", 32'(release_pulse), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_sync_edge1", 32'(rst_sync_n), 32'd0);
    @(negedge clk);
    check("rst_sync_edge2", 32'(rst_sync_n), 32'd1);
    repeat (3) @(negedge clk);

    // Clean press then release on ch0.
    raw_in[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("lat_level", 32'(level[0]), 32'(i >= 5));
      check("lat_press", 32'(press[0]), 32'(i == 5));
    end
    raw_in[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("lat_release", 32'(release_pulse[0]), 32'(i == 5));
    end
    settle(4);

    // Three-cycle glitch must be rejected.
    cnt0 = 0;
    raw_in[0] = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (i == 2) raw_in[0] = 1'b0;
      cnt0 += int'(press[0]) + int'(release_pulse[0]) + int'(level[0]);
    end
    check("glitch_activity", 32'(cnt0), 32'd0);

    // Auto-repeat on ch0, none on ch1.
    repeat_en = 2'b01;
    raw_in    = 2'b11;
    cnt1 = 0;
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      if (press[0]) q0.push_back(i);
      cnt1 += int'(press[1]);
    end
    check("rpt_cnt_ch0", 32'(q0.size()), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < q0.size())
        check("rpt_at_ch0", 32'(q0[k]), 32'((k == 0) ? 5 : 5 + DLY + PER * (k - 1)));
    end
    check("rpt_cnt_ch1", 32'(cnt1), 32'd1);
    settle(12);

    // Release landing on the edge a repeat was due: release only.
    raw_in[0] = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (i == 5) raw_in[0] = 1'b0;
      check("due_press", 32'(press[0]), 32'(i == 5));
      check("due_release", 32'(release_pulse[0]), 32'(i == 11));
    end
    settle(8);

    // Simultaneous ch0 press and ch1 release.
    repeat_en = 2'b00;
    raw_in = 2'b10;
    repeat (10) @(negedge clk);
    raw_in = 2'b01;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("sim_press0", 32'(press[0]), 32'(i == 5));
      check("sim_release1", 32'(release_pulse[1]), 32'(i == 5));
    end
    settle(12);

    // ena low for 5 cycles mid-debounce delays the level change by 5.
    raw_in[0] = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i == 1) ena = 1'b0;
      if (i == 6) ena = 1'b1;
      check("ena_level", 32'(level[0]), 32'(i >= 10));
      check("ena_press", 32'(press[0]), 32'(i == 10));
    end
    settle(12);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(7) == 0) raw_in[c] = ~raw_in[c];
        if ($urandom_range(63) == 0) repeat_en[c] = ~repeat_en[c];
      end
      ena = ($urandom_range(9) != 0);
    end

    // Asynchronous reset in the middle of a repeating hold.
    ena = 1'b1; repeat_en = 2'b11; raw_in = 2'b11;
    repeat (12) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_rst_sync_n", 32'(rst_sync_n), 32'd0);
    check("arst_level", 32'(level), 32'd0);
    check("arst_press", 32'(press), 32'd0);
    check("arst_release", 32'(release_pulse), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rerst_edge1", 32'(rst_sync_n), 32'd0);
    @(negedge clk);
    check("rerst_edge2", 32'(rst_sync_n), 32'd1);
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
